// File: rtl/rca_sum_fifo.sv
// Capture stage behind the ripple-carry adder: stores {wrap, sum} per accepted
// triple in a small FIFO and serves it over valid/ready, flagging lost results.
module rca_sum_fifo #(
  parameter int unsigned NBIT  = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] in_a,
  input  logic [NBIT-1:0] in_b,
  input  logic [NBIT-1:0] in_s,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NBIT-1:0] out_s,
  output logic            out_wrap,
  output logic [AW:0]     count,
  output logic            drop_err
);

  localparam int unsigned EW = NBIT + 1;

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          drop_q, drop_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head;
  logic          empty, full, push, pop, wrap;
  logic          unused_in_b;

  // Operand b only travels with the triple; it is never stored.
  assign unused_in_b = ^in_b;

  // Pointer MSB is the lap bit, so equal indices split into empty/full by it.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Unsigned sum smaller than an operand means the carry-out was dropped.
  assign wrap = (in_s < in_a);
  assign push = in_valid && !full;
  assign pop  = !empty && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (in_valid && full) drop_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage carries no reset; stale entries are masked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {wrap, in_s};
  end

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid = !empty;
  assign out_s     = empty ? '0 : head[NBIT-1:0];
  assign out_wrap  = empty ? 1'b0 : head[NBIT];
  assign in_ready  = !full;
  assign count     = count_q;
  assign drop_err  = drop_q;

endmodule

// File: doc/rca_sum_fifo.md
Name: rca_sum_fifo

Overview:
- Downstream capture stage for the combinational ripple-carry adder. It samples each operand pair and its NBIT sum, and derives the unsigned wrap flag, which is the carry-out the adder drops.
- Results are buffered in a DEPTH-entry FIFO and presented to the consumer over a valid/ready handshake.
- It decouples the adder from back-pressure and records any result lost when the buffer is full.

Parameters:
- NBIT, 8, operand/sum width; must match the adder's NBIT from the shared constants.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AW, log2(DEPTH), pointer index width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents a valid a/b/s triple this cycle.
- in_ready  output  1  high when the FIFO is not full.
- in_a  input  NBIT  adder operand a.
- in_b  input  NBIT  adder operand b.
- in_s  input  NBIT  adder sum s, the adder's output.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head this cycle.
- out_s  output  NBIT  sum at the FIFO head.
- out_wrap  output  1  wrap flag stored with the head entry.
- count  output  AW+1  number of occupied entries, 0..DEPTH.
- drop_err  output  1  sticky: a triple was presented while full.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_ptr = wr_ptr = 0, count = 0, drop_err = 0, out_valid = 0, out_s = 0, out_wrap = 0, in_ready = 1.
  - Memory contents are don't-care.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Pointers:
  - rd_ptr and wr_ptr are AW+1 bits; the MSB is a wrap bit.
  - empty = (rd_ptr == wr_ptr).
  - full = index bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Wrap flag: wrap = (in_s < in_a), unsigned compare, computed on the input triple and stored alongside in_s. For NBIT-bit unsigned add this equals the dropped carry-out. in_b is used only as part of the accepted triple, not in storage.
- Write (push):
  - Occurs when in_valid && !full, as registered at the start of the cycle.
  - mem[wr_ptr index] <= {wrap, in_s}; wr_ptr increments.
- Write while full:
  - in_valid && full means the triple is dropped.
  - drop_err <= 1 on that edge and stays 1 until reset.
  - No state other than drop_err changes.
- Read (pop):
  - Occurs when out_valid && out_ready; rd_ptr increments.
  - out_valid = !empty.
  - out_s/out_wrap = mem[rd_ptr index] when !empty; they are forced to 0 when empty.
- Latency: a triple written on edge N is visible at out_s with out_valid = 1 after edge N, i.e. one cycle. There is no bypass from in_s to out_s when empty.
- Simultaneous push and pop:
  - Not full and not empty: both occur, count unchanged.
  - Empty: only the push occurs, since out_valid = 0.
  - Full: only the pop occurs. The input is dropped and drop_err is set, because in_ready reflects the full state registered at the start of the cycle.
- count: incremented on push only, decremented on pop only, unchanged on both or neither. It never exceeds DEPTH or goes below 0.
- in_ready = !full. It is combinational from registered state only, with no combinational path from in_valid or out_ready.
- Ordering is strictly FIFO.

Test Plan (NBIT=8, DEPTH=4):
- Reset, then a=0x03 b=0x04 s=0x07 in_valid for 1 cycle -> next cycle out_valid=1, out_s=0x07, out_wrap=0, count=1. Pulse out_ready -> count=0, out_s=0.
- a=0xF0 b=0x20 s=0x10 -> out_s=0x10, out_wrap=1. Also a=0xFF b=0x01 s=0x00 -> out_wrap=1. a=0x00 b=0x00 s=0x00 -> out_wrap=0.
- Push 4 triples (s=0x11,0x22,0x33,0x44) with out_ready=0 -> count=4, in_ready=0. Push 5th (s=0x55) -> dropped, drop_err=1. Drain -> 0x11,0x22,0x33,0x44 in order; drop_err remains 1.
- Full FIFO, in_valid=1 (s=0x66) and out_ready=1 in the same cycle -> head 0x11 popped, 0x66 dropped, count=3, drop_err=1.
- count=2, continuous push+pop for 10 cycles with incrementing s -> count stays 2, pointers wrap past 2*DEPTH, output sequence lags input by 2 with no loss.
- Fill to count=3, assert rst_n=0 between edges -> out_valid, count, drop_err go to 0 immediately. After release, a new push of s=0x99 appears first at the output.
